// File: rtl/sync_debounce_pkg.sv
// Shared types and helpers for the sync_debounce level qualifier.
package sync_debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    QUAL_HI   = 2'b01,
    STABLE_HI = 2'b11,
    QUAL_LO   = 2'b10
  } state_t;

  // Width needed to hold values 0..stable_cycles.
  function automatic int cnt_width(input int stable_cycles);
    return $clog2(stable_cycles + 1);
  endfunction

endpackage

// File: rtl/sync_debounce_qcnt.sv
// Qualification counter: counts consecutive samples that differ from the accepted level.
module sync_debounce_qcnt
  import sync_debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  localparam int QW = cnt_width(STABLE_CYCLES);

  logic [QW-1:0] qual_cnt;

  // Clear wins over increment so an acceptance or glitch always restarts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qual_cnt <= '0;
    end else if (clr) begin
      qual_cnt <= '0;
    end else if (inc) begin
      qual_cnt <= qual_cnt + QW'(1);
    end
  end

  assign tc = (qual_cnt == QW'(STABLE_CYCLES - 1));

endmodule

// File: rtl/sync_debounce.sv
// Debounces an already-synchronised level and emits rise/fall pulses.
// Optional saturating edge counter enabled by `define SYNC_DEBOUNCE_EVT_CNT_EN.
module sync_debounce
  import sync_debounce_pkg::*;
#(
  parameter bit INIT          = 1'b0,
  parameter int STABLE_CYCLES = 4,
  parameter int EVT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in,
  input  logic             en,
  output logic             level,
  output logic             rise,
  output logic             fall,
  input  logic             evt_clr,
  output logic [EVT_W-1:0] evt_cnt
);

  state_t state;
  logic   q_clr;
  logic   q_inc;
  logic   q_tc;
  logic   accept;

  sync_debounce_qcnt #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_qcnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (q_clr),
    .inc  (q_inc),
    .tc   (q_tc)
  );

  // Counter control and edge-acceptance decode; everything is frozen while en=0.
  always_comb begin
    q_clr  = 1'b0;
    q_inc  = 1'b0;
    accept = 1'b0;
    if (en) begin
      case (state)
        STABLE_LO: if (in) begin
          if (STABLE_CYCLES == 1) accept = 1'b1;
          else                    q_inc  = 1'b1;
        end
        QUAL_HI: begin
          if (!in)       q_clr = 1'b1;
          else if (q_tc) begin
            q_clr  = 1'b1;
            accept = 1'b1;
          end else       q_inc = 1'b1;
        end
        STABLE_HI: if (!in) begin
          if (STABLE_CYCLES == 1) accept = 1'b1;
          else                    q_inc  = 1'b1;
        end
        QUAL_LO: begin
          if (in)        q_clr = 1'b1;
          else if (q_tc) begin
            q_clr  = 1'b1;
            accept = 1'b1;
          end else       q_inc = 1'b1;
        end
        default: q_clr = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT ? STABLE_HI : STABLE_LO;
      level <= INIT;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (en) begin
        case (state)
          STABLE_LO: if (in) begin
            if (STABLE_CYCLES == 1) begin
              state <= STABLE_HI;
              level <= 1'b1;
              rise  <= 1'b1;
            end else begin
              state <= QUAL_HI;
            end
          end
          QUAL_HI: begin
            if (!in) begin
              state <= STABLE_LO;
            end else if (q_tc) begin
              state <= STABLE_HI;
              level <= 1'b1;
              rise  <= 1'b1;
            end
          end
          STABLE_HI: if (!in) begin
            if (STABLE_CYCLES == 1) begin
              state <= STABLE_LO;
              level <= 1'b0;
              fall  <= 1'b1;
            end else begin
              state <= QUAL_LO;
            end
          end
          QUAL_LO: begin
            if (in) begin
              state <= STABLE_HI;
            end else if (q_tc) begin
              state <= STABLE_LO;
              level <= 1'b0;
              fall  <= 1'b1;
            end
          end
          default: begin
            state <= level ? STABLE_HI : STABLE_LO;
          end
        endcase
      end
    end
  end

`ifdef SYNC_DEBOUNCE_EVT_CNT_EN
  // Clear takes priority but still counts an edge accepted in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_cnt <= '0;
    end else if (en) begin
      if (evt_clr) begin
        evt_cnt <= accept ? EVT_W'(1) : '0;
      end else if (accept && (evt_cnt != '1)) begin
        evt_cnt <= evt_cnt + EVT_W'(1);
      end
    end
  end
`else
  logic unused_evt_clr;
  assign unused_evt_clr = evt_clr;
  assign evt_cnt        = '0;
`endif

endmodule

// File: tb/tb_sync_debounce.sv
// Self-checking bench: two DUT configurations driven in lockstep against a run-length reference model.
module tb_sync_debounce;

  localparam bit INIT_A = 1'b0;
  localparam bit INIT_B = 1'b1;
  localparam int N_A    = 4;
  localparam int N_B    = 1;
  localparam int MAX_A  = 3;
  localparam int MAX_B  = 65535;
`ifdef SYNC_DEBOUNCE_EVT_CNT_EN
  localparam bit EVT_ON = 1'b1;
`else
  localparam bit EVT_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in;
  logic        en;
  logic        evt_clr;
  logic        level_a, rise_a, fall_a;
  logic        level_b, rise_b, fall_b;
  logic [1:0]  evt_a;
  logic [15:0] evt_b;

  int checks   = 0;
  int failures = 0;

  bit m_level [2];
  int m_run   [2];
  bit m_rise  [2];
  bit m_fall  [2];
  int m_evt   [2];

  typedef struct {
    logic in;
    logic en;
    logic level;
    logic rise;
    logic fall;
    int   evt;
  } vec_t;

  vec_t tbl [23];

  always #5 clk = ~clk;

  sync_debounce #(.INIT(INIT_A), .STABLE_CYCLES(N_A), .EVT_W(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .in(in), .en(en),
    .level(level_a), .rise(rise_a), .fall(fall_a),
    .evt_clr(evt_clr), .evt_cnt(evt_a)
  );

  sync_debounce #(.INIT(INIT_B), .STABLE_CYCLES(N_B), .EVT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .in(in), .en(en),
    .level(level_b), .rise(rise_b), .fall(fall_b),
    .evt_clr(evt_clr), .evt_cnt(evt_b)
  );

  task automatic model_reset();
    m_level[0] = INIT_A;
    m_level[1] = INIT_B;
    for (int d = 0; d < 2; d++) begin
      m_run[d]  = 0;
      m_rise[d] = 1'b0;
      m_fall[d] = 1'b0;
      m_evt[d]  = 0;
    end
  endtask

  // The level flips once the input has disagreed with it for N enabled samples in a row.
  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      automatic int  n     = (d == 0) ? N_A : N_B;
      automatic int  emax  = (d == 0) ? MAX_A : MAX_B;
      automatic bit  edged = 1'b0;
      m_rise[d] = 1'b0;
      m_fall[d] = 1'b0;
      if (en) begin
        if (in != m_level[d]) begin
          m_run[d] = m_run[d] + 1;
          if (m_run[d] >= n) begin
            m_level[d] = in;
            m_rise[d]  = in;
            m_fall[d]  = !in;
            m_run[d]   = 0;
            edged      = 1'b1;
          end
        end else begin
          m_run[d] = 0;
        end
        if (evt_clr)                   m_evt[d] = edged ? 1 : 0;
        else if (edged && m_evt[d] < emax) m_evt[d] = m_evt[d] + 1;
      end
    end
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic check_all();
    check_output("level_a", 32'(level_a), 32'(m_level[0]));
    check_output("rise_a",  32'(rise_a),  32'(m_rise[0]));
    check_output("fall_a",  32'(fall_a),  32'(m_fall[0]));
    check_output("evt_a",   32'(evt_a),   EVT_ON ? 32'(m_evt[0]) : 32'd0);
    check_output("level_b", 32'(level_b), 32'(m_level[1]));
    check_output("rise_b",  32'(rise_b),  32'(m_rise[1]));
    check_output("fall_b",  32'(fall_b),  32'(m_fall[1]));
    check_output("evt_b",   32'(evt_b),   EVT_ON ? 32'(m_evt[1]) : 32'd0);
  endtask

  task automatic apply_stimulus(input logic i_in, input logic i_en, input logic i_clr, input logic i_rst);
    @(negedge clk);
    in      = i_in;
    en      = i_en;
    evt_clr = i_clr;
    rst_n   = i_rst;
    if (!i_rst) model_reset();
    @(posedge clk);
    if (rst_n) model_step();
    else       model_reset();
    #1;
    check_all();
  endtask

  initial begin
    automatic logic cur_in   = 1'b0;
    automatic int   run_left = 0;

    // Hand-computed trace for dut_a (N=4, INIT=0, EVT_W=2), outputs seen after each edge.
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2};
    tbl[14] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2};
    tbl[15] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2};
    tbl[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2};
    tbl[17] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2};
    tbl[18] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2};
    tbl[19] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2};
    tbl[20] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2};
    tbl[21] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3};
    tbl[22] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3};

    rst_n   = 1'b0;
    in      = 1'b0;
    en      = 1'b1;
    evt_clr = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_level_a", 32'(level_a), 32'(INIT_A));
    check_output("reset_level_b", 32'(level_b), 32'(INIT_B));
    check_all();

    for (int i = 0; i < 23; i++) begin
      apply_stimulus(tbl[i].in, tbl[i].en, 1'b0, 1'b1);
      check_output($sformatf("tbl%0d_level", i), 32'(level_a), 32'(tbl[i].level));
      check_output($sformatf("tbl%0d_rise", i),  32'(rise_a),  32'(tbl[i].rise));
      check_output($sformatf("tbl%0d_fall", i),  32'(fall_a),  32'(tbl[i].fall));
      check_output($sformatf("tbl%0d_evt", i),   32'(evt_a),   EVT_ON ? 32'(tbl[i].evt) : 32'd0);
    end

    // Saturation of the 2-bit counter, then a clear coinciding with the sixth edge.
    repeat (4) apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1);
    check_output("sat_edge4_fall", 32'(fall_a), 32'd1);
    check_output("sat_edge4_evt",  32'(evt_a),  EVT_ON ? 32'd3 : 32'd0);
    repeat (4) apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1);
    check_output("sat_edge5_rise", 32'(rise_a), 32'd1);
    check_output("sat_edge5_evt",  32'(evt_a),  EVT_ON ? 32'd3 : 32'd0);
    repeat (3) apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1);
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b1);
    check_output("clr_edge6_fall", 32'(fall_a), 32'd1);
    check_output("clr_edge6_evt",  32'(evt_a),  EVT_ON ? 32'd1 : 32'd0);

    // Reset in the middle of a qualification discards the pending change.
    repeat (2) apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_output("midreset_level_a", 32'(level_a), 32'(INIT_A));
    check_output("midreset_rise_a",  32'(rise_a),  32'd0);
    check_all();
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (3) apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1);
    check_output("postreset_norise", 32'(rise_a), 32'd0);
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1);
    check_output("postreset_rise", 32'(rise_a), 32'd1);

    for (int c = 0; c < 3000; c++) begin
      automatic logic r_en;
      automatic logic r_clr;
      automatic logic r_rst;
      if (run_left == 0) begin
        cur_in   = ~cur_in;
        run_left = $urandom_range(1, 7);
      end
      run_left--;
      r_en  = ($urandom_range(0, 9) != 0);
      r_clr = r_en && ($urandom_range(0, 29) == 0);
      r_rst = ($urandom_range(0, 199) != 0);
      apply_stimulus(cur_in, r_en, r_clr, r_rst);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
